// File: rtl/uart_rx_pkg.sv
// Shared types, tick constants and the parity helper for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // Returns the parity bit a correct transmitter would have sent.
    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic       bit8,
                                         input logic       odd_n_even);
        parity_calc = (^data[6:0]) ^ (bit8 & data[7]) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Brings rx into the clk domain and majority-votes the last three baud-tick samples.
module uart_rx_filter (
    input  logic clk,
    input  logic reset,
    input  logic baud_clock,
    input  logic rx,
    output logic rx_filt
);

    logic [1:0] sync_q, sync_d;
    logic [2:0] hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[0], rx};
        hist_d = hist_q;
        if (baud_clock) begin
            hist_d = {hist_q[1:0], sync_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rx_filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: deframes 7/8-bit characters with optional parity into a one-entry
// holding register with ready/read handshake and parity/framing/overflow status.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter bit RX_LEGACY_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_data_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    logic rx_filt;

    uart_rx_filter u_filter (
        .clk       (clk),
        .reset     (reset),
        .baud_clock(baud_clock),
        .rx        (rx),
        .rx_filt   (rx_filt)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic       bit8_q, bit8_d;
    logic       par_en_q, par_en_d;
    logic       odd_q, odd_d;
    logic       stop_done_q, stop_done_d;
    logic       armed_q, armed_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rdy_q, rdy_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       ovf_q, ovf_d;
    logic       load;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        bit8_d      = bit8_q;
        par_en_d    = par_en_q;
        odd_d       = odd_q;
        stop_done_d = stop_done_q;
        armed_d     = armed_q;
        load        = 1'b0;

        if (baud_clock) begin
            // A new start edge is only accepted once the line has been seen high.
            if (rx_filt) begin
                armed_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (armed_q && !rx_filt) begin
                        state_d    = START;
                        tick_cnt_d = 4'd0;
                    end
                end
                START: begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = 4'd0;
                        if (rx_filt) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = 3'd0;
                            shift_d   = 8'h00;
                            perr_d    = 1'b0;
                            bit8_d    = bit8;
                            par_en_d  = parity_en;
                            odd_d     = odd_n_even;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        shift_d[bit_cnt_q] = rx_filt;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == (bit8_q ? 3'd7 : 3'd6)) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        perr_d  = rx_filt ^ parity_calc(shift_q, bit8_q, odd_q);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (stop_done_q) begin
                        if (tick_cnt_q == MID_TICK) begin
                            state_d     = IDLE;
                            tick_cnt_d  = 4'd0;
                            stop_done_d = 1'b0;
                        end
                    end else if (tick_cnt_q == LAST_TICK) begin
                        load = 1'b1;
                        if (!rx_filt) begin
                            armed_d = 1'b0;
                        end
                        if (RX_LEGACY_MODE) begin
                            stop_done_d = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            tick_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: a load always beats a same-cycle read.
    always_comb begin
        rx_byte_d = rx_byte_q;
        rdy_d     = rdy_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ovf_d     = ovf_q;
        if (load) begin
            if (!rdy_q || read_rx_byte) begin
                rx_byte_d = shift_q;
                pe_d      = par_en_q & perr_q;
                fe_d      = ~rx_filt;
                rdy_d     = 1'b1;
                ovf_d     = 1'b0;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (read_rx_byte && rdy_q) begin
            rdy_d = 1'b0;
            pe_d  = 1'b0;
            fe_d  = 1'b0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            perr_q      <= 1'b0;
            bit8_q      <= 1'b0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            stop_done_q <= 1'b0;
            armed_q     <= 1'b1;
            rx_byte_q   <= 8'h00;
            rdy_q       <= 1'b0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            bit8_q      <= bit8_d;
            par_en_q    <= par_en_d;
            odd_q       <= odd_d;
            stop_done_q <= stop_done_d;
            armed_q     <= armed_d;
            rx_byte_q   <= rx_byte_d;
            rdy_q       <= rdy_d;
            pe_q        <= pe_d;
            fe_q        <= fe_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_data_ready = rdy_q;
    assign parity_err    = pe_q;
    assign framing_err   = fe_q;
    assign overflow      = ovf_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver for the UART core. Consumes the 16x baud_clock tick from the baud generator and samples the asynchronous rx line at mid-bit.
- Deframes start, 7/8 data, optional parity and stop bits into a single-entry receive holding register.
- Presents that register to the APB/FIFO control side with a ready/read handshake plus parity, framing and overflow status.

Parameters:
- RX_LEGACY_MODE, 0, 1 = return to IDLE only after the full stop bit (16 ticks); 0 = return at the stop-bit mid sample.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- baud_clock  input  1  one-clk-wide 16x oversample tick
- rx  input  1  asynchronous serial input, idle high
- bit8  input  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  input  1  parity bit present
- odd_n_even  input  1  1 = odd parity, 0 = even
- read_rx_byte  input  1  one-clk pulse: host consumed rx_byte
- rx_byte  output  8  received data, LSB first on the line; bit7 = 0 in 7-bit mode
- rx_data_ready  output  1  holding register full
- parity_err  output  1  parity mismatch on held byte
- framing_err  output  1  stop bit sampled 0
- overflow  output  1  byte lost because holding register was full

Behaviour:
- Reset: all outputs 0. Filter history and synchronizer flops = 1. State = IDLE, tick counter = 0, bit counter = 0. Reset mid-frame discards the partial byte; no status is set.
- Input conditioning:
  - rx passes through a 2-flop synchronizer on clk.
  - On each baud_clock tick, shift the synchronized value into a 3-bit history.
  - rx_filt = majority(history).
- All state-machine activity below happens only on clk edges where baud_clock = 1. Between ticks, all registers hold.
- States IDLE, START, DATA, PARITY, STOP. tick_cnt is 4 bits.
  - IDLE: rx_filt = 0 → START, tick_cnt = 0.
  - START: tick_cnt increments. At tick_cnt = 7 (mid-bit): if rx_filt = 1 → IDLE (false start, no status). Otherwise tick_cnt = 0, bit_cnt = 0, go to DATA.
  - DATA: tick_cnt increments, wrapping 15→0. At tick_cnt = 15, sample rx_filt into shift[bit_cnt] and increment bit_cnt. After bit_cnt reaches 6 (bit8 = 0) or 7 (bit8 = 1): go to PARITY if parity_en, else STOP.
  - PARITY: at tick_cnt = 15, sample the parity bit. Required parity = XOR(data bits) XOR odd_n_even. perr = (sampled bit ≠ required parity). Go to STOP.
  - STOP: at tick_cnt = 15, sample the stop bit and perform the load event (below). If RX_LEGACY_MODE = 0 → IDLE immediately. Otherwise remain 8 further ticks, then → IDLE.
- bit8, parity_en and odd_n_even are captured at the START→DATA transition. Changes mid-frame have no effect.
- Load event, same clk as the stop sample:
  - rx_data_ready = 0, or read_rx_byte = 1 in the same clk: rx_byte ← shift, parity_err ← perr (0 if parity disabled), framing_err ← ~stop, rx_data_ready ← 1.
  - rx_data_ready = 1 and no read: new byte discarded, held byte/status unchanged, overflow ← 1.
- read_rx_byte with rx_data_ready = 1 and no load in the same clk: rx_data_ready, parity_err, framing_err and overflow clear next clk.
- read_rx_byte with rx_data_ready = 0: ignored.
- Simultaneous read and load: load wins, rx_data_ready stays 1, overflow is not set, and the previous overflow clears.
- Latency: rx_data_ready rises one clk after the baud tick at the stop-bit mid sample.
- A line held low permanently yields one frame with framing_err. The receiver then waits in IDLE and does not re-trigger until rx_filt has returned high.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constants MID_TICK = 7, LAST_TICK = 15
  - function parity_calc(data, bit8, odd_n_even)
- One sub-module, uart_rx_filter: 2-flop synchronizer plus 3-tick majority, gated by baud_clock, output rx_filt.

Test Plan:
- Common setup: baud_clock every 4 clk (64 clk per bit).
- 8N1 0xA5 → rx_byte = 0xA5, rx_data_ready = 1 within 1 clk of the stop mid tick; parity_err, framing_err and overflow all 0. read_rx_byte → ready = 0 next clk.
- 8E1 0x3C sent with parity bit 1 (wrong) → rx_byte = 0x3C, parity_err = 1. Same byte with parity 0 → parity_err = 0. Also check 7O1 0x55 → rx_byte = 0x55, bit7 = 0.
- rx low glitch of 16 clk (4 ticks) → no START→DATA transition, rx_data_ready stays 0. A 2-clk glitch is rejected by the filter, with state remaining IDLE.
- Two 8N1 bytes 0x11 then 0x22, no read → rx_byte = 0x11, overflow = 1. Repeat with read_rx_byte on the exact load clk → rx_byte = 0x22, overflow = 0.
- Byte 0xFF with stop bit 0 → framing_err = 1. Next good frame 0x00 after a read → framing_err = 0. A back-to-back frame whose start edge falls 1 tick after the stop mid sample (RX_LEGACY_MODE = 0) is received correctly.
- Assert reset during DATA bit 3 → all outputs 0, state IDLE. A following frame 0x5A is received correctly.
